hazard_stall_unit: RTL and testbench

- Pipeline hazard controller, the counterpart of the EX/MEM forwarding path. It handles every case forwarding cannot cover.
- Cases handled: load-use dependencies, where a load result is not available until after MEM; data-memory wait states; taken-branch flushes.
- Sits beside the ID stage. Drives stall/hold enables to the IF/ID/EX/MEM pipeline registers and bubble/flush controls to the ID/EX and IF/ID registers.

---
 rtl/hazard_stall_unit_pkg.sv | 26 ++
 rtl/hazard_stall_unit_if.sv | 55 +++++
 rtl/hazard_detect_comb.sv | 35 +++
 rtl/hazard_stall_unit.sv | 178 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard stall unit.
// Holds the load-opcode range and its decode function, the FSM state
// encodings used by the state debug tap, and the common field widths.
package hazard_stall_unit_pkg;

   localparam int unsigned REG_W       = 5;
   localparam int unsigned OP_W        = 6;
   localparam int unsigned WAIT_CNT_W  = 16;
   localparam int unsigned STALL_CNT_W = 2;

   // Load opcodes occupy the contiguous range 32..38 (lb..lwr)
   localparam logic [OP_W-1:0] OP_LOAD_FIRST = 6'd32;
   localparam logic [OP_W-1:0] OP_LOAD_LAST  = 6'd38;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_LOAD_STALL = 2'd1,
      ST_MEM_WAIT   = 2'd2,
      ST_FLUSH      = 2'd3
   } hsu_state_e;

   function automatic logic is_load_op(input logic [OP_W-1:0] op);
      return (op >= OP_LOAD_FIRST) && (op <= OP_LOAD_LAST);
   endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-side bundle of the hazard stall unit.
// Inputs : ID source fields/uses, EX opcode/rd/write-enable, MEM access and
//          ready, EX branch-taken.
// Outputs: stall_if, stall_id, stall_ex_mem, bubble_ex, flush_if_id,
//          mem_timeout, state_dbg; with HAZARD_STATS_EN also stall_cycles,
//          flush_count, load_use_count.
// slave modport is the hazard unit, master modport is the pipeline.
interface hazard_stall_unit_if;
   import hazard_stall_unit_pkg::*;

   logic [REG_W-1:0] rs_id;
   logic [REG_W-1:0] rt_id;
   logic             uses_rs_id;
   logic             uses_rt_id;
   logic [OP_W-1:0]  op_ex;
   logic [REG_W-1:0] rd_ex;
   logic             register_write_ex;
   logic             mem_access_mem;
   logic             mem_ready;
   logic             branch_taken_ex;

   logic             stall_if;
   logic             stall_id;
   logic             stall_ex_mem;
   logic             bubble_ex;
   logic             flush_if_id;
   logic             mem_timeout;
   logic [1:0]       state_dbg;
`ifdef HAZARD_STATS_EN
   logic [31:0]      stall_cycles;
   logic [15:0]      flush_count;
   logic [15:0]      load_use_count;
`endif

   modport slave (
      input  rs_id, rt_id, uses_rs_id, uses_rt_id, op_ex, rd_ex,
             register_write_ex, mem_access_mem, mem_ready, branch_taken_ex,
      output stall_if, stall_id, stall_ex_mem, bubble_ex, flush_if_id,
             mem_timeout, state_dbg
`ifdef HAZARD_STATS_EN
      , output stall_cycles, flush_count, load_use_count
`endif
   );

   modport master (
      output rs_id, rt_id, uses_rs_id, uses_rt_id, op_ex, rd_ex,
             register_write_ex, mem_access_mem, mem_ready, branch_taken_ex,
      input  stall_if, stall_id, stall_ex_mem, bubble_ex, flush_if_id,
             mem_timeout, state_dbg
`ifdef HAZARD_STATS_EN
      , input stall_cycles, flush_count, load_use_count
`endif
   );

endinterface

// File: rtl/hazard_detect_comb.sv
// Purely combinational hazard detection, shared with forwarding-disable logic.
// Inputs : ID rs/rt and their use flags, EX opcode/rd/write-enable,
//          MEM access and ready.
// Outputs: o_load_use_c (ID needs a load result still in EX),
//          o_mem_wait_c (MEM access not completing this cycle).
module hazard_detect_comb
   import hazard_stall_unit_pkg::*;
(
   input  logic [REG_W-1:0] i_rs_id,
   input  logic [REG_W-1:0] i_rt_id,
   input  logic             i_uses_rs_id,
   input  logic             i_uses_rt_id,
   input  logic [OP_W-1:0]  i_op_ex,
   input  logic [REG_W-1:0] i_rd_ex,
   input  logic             i_register_write_ex,
   input  logic             i_mem_access_mem,
   input  logic             i_mem_ready,
   output logic             o_load_use_c,
   output logic             o_mem_wait_c
);

   logic w_rs_hit;
   logic w_rt_hit;

   // Unused operands are masked so stale register fields never stall
   assign w_rs_hit = i_uses_rs_id && (i_rs_id == i_rd_ex);
   assign w_rt_hit = i_uses_rt_id && (i_rt_id == i_rd_ex);

   // r0 is hardwired, so a load targeting it never creates a dependency
   assign o_load_use_c = is_load_op(i_op_ex) && i_register_write_ex &&
                         (i_rd_ex != '0) && (w_rs_hit || w_rt_hit);

   assign o_mem_wait_c = i_mem_access_mem && !i_mem_ready;

endmodule

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory wait stalls and
// taken-branch flushes. Outputs are combinational from state and inputs.
// Ports: clk, rst (async, active-high), bus (hazard_stall_unit_if.slave).
// Parameters: LOAD_STALL_CYCLES (1..3), MEM_WAIT_MAX (1..65535).
// Optional: define HAZARD_STATS_EN to add saturating event counters.
module hazard_stall_unit
   import hazard_stall_unit_pkg::*;
#(
   parameter int unsigned LOAD_STALL_CYCLES = 1,
   parameter int unsigned MEM_WAIT_MAX      = 255
) (
   input  logic                clk,
   input  logic                rst,
   hazard_stall_unit_if.slave  bus
);

   localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

   hsu_state_e              r_state;
   hsu_state_e              w_state_nxt;
   logic [STALL_CNT_W-1:0]  r_stall_cnt;
   logic [STALL_CNT_W-1:0]  w_stall_cnt_nxt;
   logic [WAIT_CNT_W-1:0]   r_wait_cnt;
   logic [WAIT_CNT_W-1:0]   w_wait_cnt_nxt;
   logic                    r_mem_timeout;
   logic                    w_timeout_set;
   logic                    w_load_use;
   logic                    w_mem_wait;
   logic                    w_stall_if;
   logic                    w_stall_id;
   logic                    w_stall_ex_mem;
   logic                    w_bubble_ex;
   logic                    w_flush_if_id;

   hazard_detect_comb u_detect (
      .i_rs_id             (bus.rs_id),
      .i_rt_id             (bus.rt_id),
      .i_uses_rs_id        (bus.uses_rs_id),
      .i_uses_rt_id        (bus.uses_rt_id),
      .i_op_ex             (bus.op_ex),
      .i_rd_ex             (bus.rd_ex),
      .i_register_write_ex (bus.register_write_ex),
      .i_mem_access_mem    (bus.mem_access_mem),
      .i_mem_ready         (bus.mem_ready),
      .o_load_use_c        (w_load_use),
      .o_mem_wait_c        (w_mem_wait)
   );

   // State, counters and sticky timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_RUN;
         r_stall_cnt   <= '0;
         r_wait_cnt    <= '0;
         r_mem_timeout <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_stall_cnt   <= w_stall_cnt_nxt;
         r_wait_cnt    <= w_wait_cnt_nxt;
         r_mem_timeout <= r_mem_timeout | w_timeout_set;
      end
   end

   // Next state and pipeline controls
   always_comb begin
      w_state_nxt     = r_state;
      w_stall_cnt_nxt = r_stall_cnt;
      w_wait_cnt_nxt  = r_wait_cnt;
      w_stall_if      = 1'b0;
      w_stall_id      = 1'b0;
      w_stall_ex_mem  = 1'b0;
      w_bubble_ex     = 1'b0;
      w_flush_if_id   = 1'b0;

      unique case (r_state)
         // FLUSH behaves like RUN except EX holds the flushed bubble, so a
         // branch seen there is not acted on again
         ST_RUN, ST_FLUSH: begin
            w_state_nxt = ST_RUN;
            if (w_mem_wait) begin
               w_stall_if     = 1'b1;
               w_stall_id     = 1'b1;
               w_stall_ex_mem = 1'b1;
               w_wait_cnt_nxt = WAIT_CNT_W'(1);
               w_state_nxt    = ST_MEM_WAIT;
            end else if (bus.branch_taken_ex && (r_state == ST_RUN)) begin
               w_flush_if_id = 1'b1;
               w_bubble_ex   = 1'b1;
               w_state_nxt   = ST_FLUSH;
            end else if (w_load_use) begin
               w_stall_if  = 1'b1;
               w_stall_id  = 1'b1;
               w_bubble_ex = 1'b1;
               if (LOAD_STALL_CYCLES > 1) begin
                  w_stall_cnt_nxt = STALL_CNT_W'(1);
                  w_state_nxt     = ST_LOAD_STALL;
               end
            end
         end
         // A memory wait preempts the remaining bubbles; the load has moved on
         ST_LOAD_STALL: begin
            if (w_mem_wait) begin
               w_stall_if     = 1'b1;
               w_stall_id     = 1'b1;
               w_stall_ex_mem = 1'b1;
               w_wait_cnt_nxt = WAIT_CNT_W'(1);
               w_state_nxt    = ST_MEM_WAIT;
            end else begin
               w_stall_if      = 1'b1;
               w_stall_id      = 1'b1;
               w_bubble_ex     = 1'b1;
               w_stall_cnt_nxt = r_stall_cnt + STALL_CNT_W'(1);
               if (r_stall_cnt == STALL_LAST) begin
                  w_state_nxt = ST_RUN;
               end
            end
         end
         ST_MEM_WAIT: begin
            if (bus.mem_ready) begin
               w_state_nxt = ST_RUN;
            end else begin
               w_stall_if     = 1'b1;
               w_stall_id     = 1'b1;
               w_stall_ex_mem = 1'b1;
               w_wait_cnt_nxt = (r_wait_cnt == '1) ? r_wait_cnt
                                                   : r_wait_cnt + WAIT_CNT_W'(1);
            end
         end
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Timeout fires on the edge where the wait count reaches the limit
   assign w_timeout_set = w_stall_ex_mem && (32'(w_wait_cnt_nxt) >= MEM_WAIT_MAX);

   assign bus.stall_if     = !rst && w_stall_if;
   assign bus.stall_id     = !rst && w_stall_id;
   assign bus.stall_ex_mem = !rst && w_stall_ex_mem;
   assign bus.bubble_ex    = !rst && w_bubble_ex;
   assign bus.flush_if_id  = !rst && w_flush_if_id;
   assign bus.mem_timeout  = r_mem_timeout;
   assign bus.state_dbg    = r_state;

`ifdef HAZARD_STATS_EN
   logic [31:0] r_stall_cycles;
   logic [15:0] r_flush_count;
   logic [15:0] r_load_use_count;
   logic        w_flush_evt;
   logic        w_load_use_evt;

   assign w_flush_evt    = (r_state == ST_RUN) && w_flush_if_id;
   assign w_load_use_evt = (r_state == ST_RUN) && w_bubble_ex && !w_flush_if_id;

   // Saturating event counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cycles   <= '0;
         r_flush_count    <= '0;
         r_load_use_count <= '0;
      end else begin
         if (w_stall_if && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
         end
         if (w_flush_evt && (r_flush_count != '1)) begin
            r_flush_count <= r_flush_count + 16'd1;
         end
         if (w_load_use_evt && (r_load_use_count != '1)) begin
            r_load_use_count <= r_load_use_count + 16'd1;
         end
      end
   end

   assign bus.stall_cycles   = r_stall_cycles;
   assign bus.flush_count    = r_flush_count;
   assign bus.load_use_count = r_load_use_count;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed scenarios plus random
// traffic, expected outputs from a behavioural pipeline model.
module tb_hazard_stall_unit;

   localparam int unsigned LSC = 2;
   localparam int unsigned MWM = 8;

   typedef struct packed {
      logic       r;
      logic [5:0] op;
      logic [4:0] rd;
      logic       rw;
      logic [4:0] rs;
      logic [4:0] rt;
      logic       urs;
      logic       urt;
      logic       macc;
      logic       mrdy;
      logic       br;
   } stim_t;

   typedef struct packed {
      logic       sif;
      logic       sid;
      logic       sem;
      logic       bub;
      logic       fl;
      logic       to;
      logic [1:0] st;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   failures = 0;
   exp_t sb_q[$];

   // Model: remaining extra bubbles, memory-wait tracking, flush shadow
   bit m_wait;
   int m_wait_len;
   int m_bubbles;
   bit m_flush_prev;
   bit m_timeout;

   always #5 clk = ~clk;

   hazard_stall_unit_if bus();

   hazard_stall_unit #(
      .LOAD_STALL_CYCLES (LSC),
      .MEM_WAIT_MAX      (MWM)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic model_reset();
      m_wait       = 1'b0;
      m_wait_len   = 0;
      m_bubbles    = 0;
      m_flush_prev = 1'b0;
      m_timeout    = 1'b0;
   endtask

   task automatic chk(input string nm, input logic [1:0] act, input logic [1:0] ex);
      checks++;
      if (act !== ex) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, ex, $time);
      end
   endtask

   // Drive one cycle of inputs, predict that cycle's outputs, advance model
   task automatic step(input stim_t s);
      exp_t e;
      bit   lu;
      bit   mw;
      bit   fl_next;
      @(posedge clk);
      #1;
      rst                   = s.r;
      bus.op_ex             = s.op;
      bus.rd_ex             = s.rd;
      bus.register_write_ex = s.rw;
      bus.rs_id             = s.rs;
      bus.rt_id             = s.rt;
      bus.uses_rs_id        = s.urs;
      bus.uses_rt_id        = s.urt;
      bus.mem_access_mem    = s.macc;
      bus.mem_ready         = s.mrdy;
      bus.branch_taken_ex   = s.br;
      e  = '0;
      lu = (s.op >= 6'd32) && (s.op <= 6'd38) && s.rw && (s.rd != 5'd0) &&
           ((s.urs && (s.rs == s.rd)) || (s.urt && (s.rt == s.rd)));
      mw = s.macc && !s.mrdy;
      if (s.r) begin
         model_reset();
      end else begin
         e.st = m_wait ? 2'd2 : (m_bubbles > 0) ? 2'd1 : m_flush_prev ? 2'd3 : 2'd0;
         e.to = m_timeout;
         fl_next = 1'b0;
         if (m_wait) begin
            if (s.mrdy) begin
               m_wait = 1'b0;
            end else begin
               e.sif = 1'b1; e.sid = 1'b1; e.sem = 1'b1;
               if (m_wait_len < 65535) m_wait_len++;
               if (m_wait_len >= int'(MWM)) m_timeout = 1'b1;
            end
         end else if (mw) begin
            e.sif = 1'b1; e.sid = 1'b1; e.sem = 1'b1;
            m_wait     = 1'b1;
            m_wait_len = 1;
            m_bubbles  = 0;
            if (m_wait_len >= int'(MWM)) m_timeout = 1'b1;
         end else if (m_bubbles > 0) begin
            e.sif = 1'b1; e.sid = 1'b1; e.bub = 1'b1;
            m_bubbles--;
         end else if (s.br && !m_flush_prev) begin
            e.fl = 1'b1; e.bub = 1'b1;
            fl_next = 1'b1;
         end else if (lu) begin
            e.sif = 1'b1; e.sid = 1'b1; e.bub = 1'b1;
            m_bubbles = int'(LSC) - 1;
         end
         m_flush_prev = fl_next;
      end
      sb_q.push_back(e);
   endtask

   function automatic stim_t s_load(input logic [5:0] op, input logic [4:0] rd,
                                    input logic [4:0] rs, input logic [4:0] rt,
                                    input logic urs, input logic urt);
      stim_t s;
      s     = '0;
      s.op  = op;
      s.rd  = rd;
      s.rw  = 1'b1;
      s.rs  = rs;
      s.rt  = rt;
      s.urs = urs;
      s.urt = urt;
      return s;
   endfunction

   function automatic stim_t s_mem(input logic rdy);
      stim_t s;
      s      = '0;
      s.macc = 1'b1;
      s.mrdy = rdy;
      return s;
   endfunction

   // Random traffic, steered away from conditions the pipeline cannot produce
   function automatic stim_t s_rand();
      stim_t s;
      s      = '0;
      s.op   = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(32, 38))
                                           : 6'($urandom_range(0, 63));
      s.rd   = 5'($urandom_range(0, 7));
      s.rw   = ($urandom_range(0, 9) != 0);
      s.rs   = 5'($urandom_range(0, 7));
      s.rt   = 5'($urandom_range(0, 7));
      s.urs  = ($urandom_range(0, 3) != 0);
      s.urt  = ($urandom_range(0, 1) != 0);
      s.mrdy = ($urandom_range(0, 99) < 60);
      s.macc = m_wait ? 1'b1 : (!m_flush_prev && ($urandom_range(0, 99) < 25));
      s.br   = ($urandom_range(0, 99) < 15) && (m_bubbles == 0) && !m_flush_prev;
      return s;
   endfunction

   // Monitor: compares every presented cycle against the scoreboard
   always @(negedge clk) begin
      exp_t e;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("stall_if",     {1'b0, bus.stall_if},     {1'b0, e.sif});
         chk("stall_id",     {1'b0, bus.stall_id},     {1'b0, e.sid});
         chk("stall_ex_mem", {1'b0, bus.stall_ex_mem}, {1'b0, e.sem});
         chk("bubble_ex",    {1'b0, bus.bubble_ex},    {1'b0, e.bub});
         chk("flush_if_id",  {1'b0, bus.flush_if_id},  {1'b0, e.fl});
         chk("mem_timeout",  {1'b0, bus.mem_timeout},  {1'b0, e.to});
         chk("state_dbg",    bus.state_dbg,            e.st);
      end
   end

   initial begin
      stim_t s;
      stim_t rst_s;
      rst                   = 1'b1;
      bus.op_ex             = '0;
      bus.rd_ex             = '0;
      bus.register_write_ex = 1'b0;
      bus.rs_id             = '0;
      bus.rt_id             = '0;
      bus.uses_rs_id        = 1'b0;
      bus.uses_rt_id        = 1'b0;
      bus.mem_access_mem    = 1'b0;
      bus.mem_ready         = 1'b0;
      bus.branch_taken_ex   = 1'b0;
      model_reset();
      rst_s   = '0;
      rst_s.r = 1'b1;

      step(rst_s);
      step(rst_s);
      step('0);

      // lw r5 followed by a reader of r5 on rs
      step(s_load(6'd35, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0));
      step('0);
      step('0);
      // rd=0, masked use, non-load opcode boundaries: no stall
      step(s_load(6'd35, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1));
      step(s_load(6'd35, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0));
      step(s_load(6'd31, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0));
      step(s_load(6'd39, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0));
      // rt path and range edges 32 / 38
      step(s_load(6'd32, 5'd7, 5'd0, 5'd7, 1'b0, 1'b1));
      step('0);
      step(s_load(6'd38, 5'd3, 5'd3, 5'd0, 1'b1, 1'b0));
      step('0);
      step('0);

      // four-cycle memory wait, then ready
      repeat (4) step(s_mem(1'b0));
      step(s_mem(1'b1));
      step('0);

      // branch together with a load-use: flush wins
      s    = s_load(6'd35, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
      s.br = 1'b1;
      step(s);
      step('0);
      step('0);

      // memory wait preempting the remaining load-use bubbles
      step(s_load(6'd35, 5'd4, 5'd4, 5'd0, 1'b1, 1'b0));
      step(s_mem(1'b0));
      step(s_mem(1'b1));
      step('0);

      // timeout after MWM wait cycles, sticky past ready
      repeat (10) step(s_mem(1'b0));
      step(s_mem(1'b1));
      step('0);
      step('0);

      // async reset in the middle of a wait
      repeat (3) step(s_mem(1'b0));
      s   = s_mem(1'b0);
      s.r = 1'b1;
      step(s);
      step(rst_s);
      step('0);

      repeat (600) step(s_rand());
      step('0);

      for (int i = 0; (i < 20) && (sb_q.size() > 0); i++) @(negedge clk);
      #1;
      checks++;
      if (sb_q.size() != 0) begin
         failures++;
         $display("FAIL drain got=%0d exp=0 pending entries", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
